// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main_memory arbiter.
//   arb_state_e : arbiter FSM state encoding (2 bits)
//   OWNER_*     : read-return tag identifying which port issued a read
//   *_W_DEF     : default address/data widths for the 256x16 memory
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CORE_LAST   = 2'd1,
    HOST_LAST   = 2'd2,
    HOST_LOCKED = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: STAGES-deep {valid, owner} shift register tracking reads in
// flight through the memory. Synchronous active-high clear drops all
// pending entries.
//   clk, rst          : clock, synchronous clear
//   i_vld, i_owner    : read issued this cycle and which port issued it
//   o_vld, o_owner    : read data is on ram_q this cycle, and its owner
module rd_tag_pipe #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_owner,
  output logic o_vld,
  output logic o_owner
);

  logic [STAGES:1] r_vld_pipe;
  logic [STAGES:1] r_own_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe[1] <= 1'b0;
      r_own_pipe[1] <= 1'b0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      r_own_pipe[1] <= i_owner;
    end
  end

  for (genvar k = 2; k <= STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld_pipe[k] <= 1'b0;
        r_own_pipe[k] <= 1'b0;
      end else begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_own_pipe[k] <= r_own_pipe[k-1];
      end
    end
  end

  assign o_vld   = r_vld_pipe[STAGES];
  assign o_owner = r_own_pipe[STAGES];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main_memory between control_fsm (core)
// and the host loader/debug port. At most one access per cycle; round-robin
// under contention, with a host lock for burst loads. Read data is routed
// back to the issuing port via a tagged valid pipeline.
//   clk, rst                         : clock, synchronous active-high reset
//   core_req/we/addr/wdata -> gnt    : core request, combinational grant
//   core_rvalid, core_rdata          : core read return
//   host_* (same as core_*)          : host port
//   host_lock                        : keeps the core out while host owns mem
//   ram_addr, ram_data, ram_wren     : to main_memory
//   ram_q                            : from main_memory, READ_LAT after issue
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_e        r_state, w_next;
  logic              w_core_gnt, w_host_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_core_rdata, r_host_rdata;
  logic              w_rd_issue, w_rd_vld, w_rd_owner;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // IDLE and HOST_LAST both favour the core; CORE_LAST favours the host.
  // Grants are suppressed during reset so nothing reaches the memory.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    w_next     = r_state;
    if (!rst) begin
      case (r_state)
        HOST_LOCKED: w_host_gnt = host_req;
        CORE_LAST: begin
          w_host_gnt = host_req;
          w_core_gnt = core_req & ~host_req;
        end
        default: begin
          w_core_gnt = core_req;
          w_host_gnt = host_req & ~core_req;
        end
      endcase
      if (w_core_gnt)
        w_next = CORE_LAST;
      else if (w_host_gnt)
        w_next = host_lock ? HOST_LOCKED : HOST_LAST;
      else if (r_state == HOST_LOCKED && !host_lock)
        w_next = HOST_LAST;
    end
  end

  assign core_gnt = w_core_gnt;
  assign host_gnt = w_host_gnt;

  // Memory-side bus: granted port's fields pass straight through; with no
  // grant the address/data hold the last issued values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_host_gnt) begin
      r_addr <= host_addr;
      r_data <= host_wdata;
    end else if (w_core_gnt) begin
      r_addr <= core_addr;
      r_data <= core_wdata;
    end
  end

  always_comb begin
    ram_addr = r_addr;
    ram_data = r_data;
    ram_wren = 1'b0;
    if (rst) begin
      ram_addr = '0;
      ram_data = '0;
    end else if (w_host_gnt) begin
      ram_addr = host_addr;
      ram_data = host_wdata;
      ram_wren = host_we;
    end else if (w_core_gnt) begin
      ram_addr = core_addr;
      ram_data = core_wdata;
      ram_wren = core_we;
    end
  end

  assign w_rd_issue = (w_core_gnt & ~core_we) | (w_host_gnt & ~host_we);

  rd_tag_pipe #(.STAGES(READ_LAT)) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (w_rd_issue),
    .i_owner (w_host_gnt ? OWNER_HOST : OWNER_CORE),
    .o_vld   (w_rd_vld),
    .o_owner (w_rd_owner)
  );

  // rst gating covers the reset cycle itself: a read already in flight
  // must not surface while reset is asserted.
  assign core_rvalid = w_rd_vld & ~rst & (w_rd_owner == OWNER_CORE);
  assign host_rvalid = w_rd_vld & ~rst & (w_rd_owner == OWNER_HOST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      if (core_rvalid) r_core_rdata <= ram_q;
      if (host_rvalid) r_host_rdata <= ram_q;
    end
  end

  assign core_rdata = rst ? '0 : (core_rvalid ? ram_q : r_core_rdata);
  assign host_rdata = rst ? '0 : (host_rvalid ? ram_q : r_host_rdata);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_gnt, core_rvalid;
  logic [7:0]  core_addr;
  logic [15:0] core_wdata, core_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid, host_lock;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data, ram_q;
  logic        ram_wren;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_lock(host_lock),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // main_memory stand-in: synchronous write, registered read (1 cycle).
  logic [15:0] mem [256];
  logic        pl_all, pl_one;
  logic [15:0] pl_key, pl_data;
  logic [7:0]  pl_addr;

  always @(posedge clk) begin
    if (pl_all) begin
      for (int i = 0; i < 256; i++) mem[i] <= (16'hC000 | 16'(i)) ^ pl_key;
    end else if (pl_one) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha,
                       input logic [15:0] hd, input logic hl);
    rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       r, cr, cw; logic [7:0] ca;
    logic       hr, hw;    logic [7:0] ha; logic [15:0] hd; logic hl;
    logic       ecg, ehg, ewr, ecrv; logic [15:0] ecrd; logic ehrv;
  } vec_t;

  vec_t vt[20];

  // reference model state
  logic [15:0] ref_mem [256];
  bit          core_first, locked;
  logic [7:0]  last_a;
  logic [15:0] last_d, exp_crd, exp_hrd;
  bit          pv, pv_host;
  logic [15:0] pv_data;
  bit          c_pend, c_we, h_pend, h_we, h_lk, ec, eh;
  logic [7:0]  c_a, h_a;
  logic [15:0] c_d, h_d;

  initial begin
    pl_all = 1'b0; pl_one = 1'b0; pl_key = '0; pl_data = '0; pl_addr = '0;
    drive(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);

    // Directed table; memory preloaded with C000|addr.
    vt[0] = '{1,1,0,8'h20, 1,1,8'h30,16'hB030,0, 0,0,0, 0,16'h0,0};
    vt[1] = '{1,1,0,8'h20, 1,1,8'h30,16'hB030,0, 0,0,0, 0,16'h0,0};
    vt[2] = '{0,1,0,8'h20, 1,1,8'h30,16'hB030,0, 1,0,0, 0,16'h0,0};
    vt[3] = '{0,1,0,8'h21, 1,1,8'h30,16'hB030,0, 0,1,1, 1,16'hC020,0};
    vt[4] = '{0,1,0,8'h21, 1,1,8'h31,16'hB031,0, 1,0,0, 0,16'h0,0};
    vt[5] = '{0,1,0,8'h22, 1,1,8'h31,16'hB031,0, 0,1,1, 1,16'hC021,0};
    vt[6] = '{0,1,0,8'h22, 1,1,8'h32,16'hB032,0, 1,0,0, 0,16'h0,0};
    vt[7] = '{0,1,0,8'h23, 1,1,8'h32,16'hB032,0, 0,1,1, 1,16'hC022,0};
    vt[8] = '{0,1,0,8'h23, 0,0,8'h00,16'h0000,0, 1,0,0, 0,16'h0,0};
    for (int i = 0; i < 8; i++)
      vt[9+i] = '{0,1,0,8'h40, 1,1,8'(i),16'hA000 | 16'(i),1, 0,1,1,
                  (i == 0), (i == 0) ? 16'hC023 : 16'h0, 0};
    vt[17] = '{0,1,0,8'h40, 0,0,8'h00,16'h0000,0, 0,0,0, 0,16'h0,0};
    vt[18] = '{0,1,0,8'h40, 0,0,8'h00,16'h0000,0, 1,0,0, 0,16'h0,0};
    vt[19] = '{0,0,0,8'h40, 0,0,8'h00,16'h0000,0, 0,0,0, 1,16'hC040,0};

    pl_all = 1'b1; next_cycle(); pl_all = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].r, vt[i].cr, vt[i].cw, vt[i].ca, 16'h0,
            vt[i].hr, vt[i].hw, vt[i].ha, vt[i].hd, vt[i].hl);
      @(negedge clk);
      chk($sformatf("tbl%0d core_gnt", i), 32'(core_gnt), 32'(vt[i].ecg));
      chk($sformatf("tbl%0d host_gnt", i), 32'(host_gnt), 32'(vt[i].ehg));
      chk($sformatf("tbl%0d ram_wren", i), 32'(ram_wren), 32'(vt[i].ewr));
      chk($sformatf("tbl%0d core_rvalid", i), 32'(core_rvalid), 32'(vt[i].ecrv));
      chk($sformatf("tbl%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].ehrv));
      if (vt[i].ecrv) chk($sformatf("tbl%0d core_rdata", i), 32'(core_rdata), 32'(vt[i].ecrd));
      if (vt[i].r) begin
        chk($sformatf("tbl%0d rst ram_addr", i), 32'(ram_addr), 32'h0);
        chk($sformatf("tbl%0d rst core_rdata", i), 32'(core_rdata), 32'h0);
      end
      next_cycle();
    end

    // Single core read of a preloaded word.
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    pl_one = 1'b1; pl_addr = 8'h10; pl_data = 16'h1234; next_cycle(); pl_one = 1'b0;
    drive(0, 1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("rd core_gnt", 32'(core_gnt), 32'h1);
    chk("rd ram_addr", 32'(ram_addr), 32'h10);
    next_cycle();
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("rd core_rvalid", 32'(core_rvalid), 32'h1);
    chk("rd core_rdata", 32'(core_rdata), 32'h1234);
    chk("rd host_rvalid", 32'(host_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rd rvalid one cycle", 32'(core_rvalid), 32'h0);
    chk("rd rdata holds", 32'(core_rdata), 32'h1234);
    next_cycle();

    // Host write then core read of the same address next cycle.
    drive(0, 0, 0, 8'h00, 16'h0, 1, 1, 8'h05, 16'hABCD, 0);
    @(negedge clk);
    chk("haz host_gnt", 32'(host_gnt), 32'h1);
    chk("haz ram_wren", 32'(ram_wren), 32'h1);
    chk("haz ram_data", 32'(ram_data), 32'hABCD);
    next_cycle();
    drive(0, 1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("haz core_gnt", 32'(core_gnt), 32'h1);
    next_cycle();
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("haz core_rvalid", 32'(core_rvalid), 32'h1);
    chk("haz core_rdata", 32'(core_rdata), 32'hABCD);
    next_cycle();

    // Reset arriving while a read is in flight.
    drive(0, 1, 0, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("rstrd core_gnt", 32'(core_gnt), 32'h1);
    next_cycle();
    drive(1, 1, 0, 8'h20, 16'h0, 1, 0, 8'h21, 16'h0, 0);
    @(negedge clk);
    chk("rstrd core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rstrd core_gnt", 32'(core_gnt), 32'h0);
    chk("rstrd host_gnt", 32'(host_gnt), 32'h0);
    chk("rstrd ram_wren", 32'(ram_wren), 32'h0);
    chk("rstrd ram_addr", 32'(ram_addr), 32'h0);
    chk("rstrd ram_data", 32'(ram_data), 32'h0);
    chk("rstrd core_rdata", 32'(core_rdata), 32'h0);
    next_cycle();
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0);
    @(negedge clk);
    chk("rstrd after core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rstrd after core_rdata", 32'(core_rdata), 32'h0);
    chk("rstrd after ram_addr", 32'(ram_addr), 32'h0);
    next_cycle();

    // Randomized traffic against the reference model.
    rst = 1'b1;
    pl_key = 16'($urandom);
    pl_all = 1'b1; next_cycle(); pl_all = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = (16'hC000 | 16'(i)) ^ pl_key;
    core_first = 1; locked = 0; last_a = '0; last_d = '0;
    exp_crd = '0; exp_hrd = '0; pv = 0; pv_host = 0; pv_data = '0;
    c_pend = 0; h_pend = 0; c_we = 0; h_we = 0;
    c_a = '0; h_a = '0; c_d = '0; h_d = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1; c_we = 1'($urandom_range(0, 1));
        c_a = 8'($urandom_range(0, 15)); c_d = 16'($urandom);
      end
      if (!h_pend && $urandom_range(0, 2) != 0) begin
        h_pend = 1; h_we = 1'($urandom_range(0, 1));
        h_a = 8'($urandom_range(0, 15)); h_d = 16'($urandom);
      end
      h_lk = ($urandom_range(0, 3) == 0);
      drive(0, c_pend, c_we, c_a, c_d, h_pend, h_we, h_a, h_d, h_lk);

      // Who should win this cycle.
      if (locked)               begin ec = 0;          eh = h_pend;      end
      else if (c_pend && h_pend) begin ec = core_first; eh = !core_first; end
      else                      begin ec = c_pend;     eh = h_pend;      end
      if (ec) begin last_a = c_a; last_d = c_d; end
      if (eh) begin last_a = h_a; last_d = h_d; end

      @(negedge clk);
      chk("rnd core_gnt", 32'(core_gnt), 32'(ec));
      chk("rnd host_gnt", 32'(host_gnt), 32'(eh));
      chk("rnd ram_wren", 32'(ram_wren), 32'((ec && c_we) || (eh && h_we)));
      chk("rnd ram_addr", 32'(ram_addr), 32'(last_a));
      chk("rnd ram_data", 32'(ram_data), 32'(last_d));
      if (pv && !pv_host) exp_crd = pv_data;
      if (pv && pv_host)  exp_hrd = pv_data;
      chk("rnd core_rvalid", 32'(core_rvalid), 32'(pv && !pv_host));
      chk("rnd host_rvalid", 32'(host_rvalid), 32'(pv && pv_host));
      chk("rnd core_rdata", 32'(core_rdata), 32'(exp_crd));
      chk("rnd host_rdata", 32'(host_rdata), 32'(exp_hrd));

      pv = 0;
      if (ec) begin
        if (c_we) ref_mem[c_a] = c_d;
        else begin pv = 1; pv_host = 0; pv_data = ref_mem[c_a]; end
        c_pend = 0; core_first = 0;
      end else if (eh) begin
        if (h_we) ref_mem[h_a] = h_d;
        else begin pv = 1; pv_host = 1; pv_data = ref_mem[h_a]; end
        h_pend = 0; core_first = 1; locked = h_lk;
      end else if (locked && !h_lk) begin
        locked = 0; core_first = 1;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 256x16 `main_memory`, sharing it between the core's `control_fsm` and a host loader/debug port. Each cycle it issues at most one access: round-robin when both request, with an optional host lock for burst program loading. Read data returns on a tagged valid pipeline, routed back to the requester that issued the read. It sits between `control_fsm` / the host port and `main_memory` in `core_top`.

## Interface
- ADDR_W, 8, memory address width (matches `ram_addr[7:0]`)
- DATA_W, 16, data word width
- READ_LAT, 1, cycles from address issue to valid `ram_q`
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core access request; held until `core_gnt`
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  access issued this cycle
- core_rvalid  out  1  `core_rdata` valid
- core_rdata  out  DATA_W  read return data
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as core_*, for the host port
- host_lock  in  1  while high and host owns the memory, the core is locked out
- ram_addr  out  ADDR_W  to `main_memory` address
- ram_data  out  DATA_W  to `main_memory` data
- ram_wren  out  1  active-high write enable
- ram_q  in  DATA_W  from `main_memory`

## Operation
- States: IDLE, CORE_LAST, HOST_LAST, HOST_LOCKED (2-bit encoding).
- IDLE: a single requester wins. If both request, core wins.
- CORE_LAST: if both request, host wins. HOST_LAST: if both request, core wins.
- After a grant, state becomes CORE_LAST or HOST_LAST to match the winner.
- If the host is granted with `host_lock`=1, state becomes HOST_LOCKED.
- HOST_LOCKED: only the host is granted, and the core waits.
  - Exit when `host_lock`=0 in a cycle with no host grant. Next state is HOST_LAST.
  - In a cycle where `host_lock` falls while `host_req`=1, the host is still granted; the core waits one more cycle.
- No request: `ram_wren`=0 and `ram_addr` holds its last value. State is unchanged, except HOST_LOCKED exits as above.
- Grant is combinational from req/state in the same cycle. The granted port's addr/we/wdata are muxed straight onto ram_*, and `ram_wren` = granted & we.
- Requesters must hold req/addr/we/wdata stable until gnt. Req is sampled freshly each cycle, so back-to-back grants to the same port are allowed.
- Reads push {valid, owner} into a READ_LAT-deep shift register. At its output, the owner's rvalid pulses for 1 cycle and its rdata = `ram_q`. Non-owner rdata holds its previous value.
- Writes produce no rvalid.

## Timing
- Reset values:
  - state = IDLE
  - all gnt/rvalid = 0
  - ram_wren = 0, ram_addr = 0, ram_data = 0
  - rdata = 0
  - read pipeline cleared
- Read latency: gnt in cycle N gives rvalid in cycle N+READ_LAT (N+1 by default).
- Write latency: the write takes effect at the edge ending cycle N.
- Throughput: 1 access per cycle. With both ports requesting continuously, grants alternate core, host, core, …
- Write then read to the same address in cycles N, N+1 returns the new data at N+2.
- Reset mid-read: pending rvalid is dropped; no rvalid is asserted after `rst`.
- The core's worst-case wait without lock is 1 cycle. With lock it is unbounded; this is the host's responsibility.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants
  - owner tag constants: OWNER_CORE=0, OWNER_HOST=1
  - ADDR_W/DATA_W defaults
- One sub-module `rd_tag_pipe`: parameterised READ_LAT-deep valid/owner shift register with synchronous clear.
- The rest is the arbiter FSM plus output muxes. Target ~150–250 lines of RTL.

## Test plan
- Reset: hold `rst` 2 cycles with both reqs high. Required: no gnt, ram_wren=0, rvalid=0. On release with both requesting, core_gnt in the first cycle.
- Single core read: preload addr 0x10=0x1234, core read 0x10. Required: core_gnt same cycle, core_rvalid next cycle with core_rdata=0x1234, host_rvalid=0.
- Contention: both request continuously for 6 cycles (core reads 0x20.., host writes 0x30..). Required: grants alternate C,H,C,H,C,H; each core rvalid routes to the core only.
- Lock: host_lock=1 writing 0x00–0x07 while core_req=1. Required: 8 consecutive host grants and no core_gnt. Drop host_lock and host_req: core_gnt the next cycle.
- Write/read hazard: host writes 0xABCD to 0x05, then core reads 0x05 next cycle. Required: core_rdata=0xABCD.
- Reset mid-read: core read granted, `rst` the following cycle. Required: no core_rvalid; all outputs at reset values.
